// File: rtl/lcd_pkg.sv
// Shared state, timing defaults and init-step record for the HD44780 4-bit sequencer.
// LCD_INIT_SEQ_EN adds the INIT_WAIT state used by the built-in power-up sequence.
package lcd_pkg;

  localparam int DEF_E_SETUP    = 2;
  localparam int DEF_E_PULSE    = 12;
  localparam int DEF_E_HOLD     = 1;
  localparam int DEF_NIBBLE_GAP = 50;
  localparam int DEF_EXEC_SHORT = 2000;
  localparam int DEF_EXEC_LONG  = 82000;
  localparam int DEF_POWERUP    = 750000;
  localparam int DEF_INIT_DLY_A = 205000;
  localparam int DEF_INIT_DLY_B = 5000;

  // Step 0 stands for the power-up wait; steps 1..8 are the nibbles and bytes sent.
  localparam int INIT_STEPS = 9;
  localparam int INIT_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP,
    EXEC
`ifdef LCD_INIT_SEQ_EN
    , INIT_WAIT
`endif
  } state_t;

  typedef enum logic [2:0] {
    DLY_SHORT,
    DLY_LONG,
    DLY_INIT_A,
    DLY_INIT_B,
    DLY_POWERUP
  } dly_sel_t;

  typedef struct packed {
    logic       single_nibble;
    logic [7:0] data;
    dly_sel_t   delay_sel;
  } init_step_t;

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Step-index to init-step lookup for the HD44780 4-bit power-up sequence.
// Single-nibble steps carry their nibble in data[7:4].
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [INIT_IDX_W-1:0] idx,
  output init_step_t            step
);

  always_comb begin
    step = '{1'b0, 8'h00, DLY_SHORT};
    case (idx)
      4'd0: step = '{1'b1, 8'h00, DLY_POWERUP};
      4'd1: step = '{1'b1, 8'h30, DLY_INIT_A};
      4'd2: step = '{1'b1, 8'h30, DLY_INIT_B};
      4'd3: step = '{1'b1, 8'h30, DLY_SHORT};
      4'd4: step = '{1'b1, 8'h20, DLY_SHORT};
      4'd5: step = '{1'b0, 8'h28, DLY_SHORT};
      4'd6: step = '{1'b0, 8'h0C, DLY_SHORT};
      4'd7: step = '{1'b0, 8'h06, DLY_SHORT};
      4'd8: step = '{1'b0, 8'h01, DLY_LONG};
      default: step = '{1'b0, 8'h00, DLY_SHORT};
    endcase
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Byte sequencer for an HD44780 LCD on its 4-bit bus: nibble split, E framing, exec delays.
// Define LCD_INIT_SEQ_EN to run the power-up init sequence before accepting bytes.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int E_SETUP     = DEF_E_SETUP,
  parameter int E_PULSE     = DEF_E_PULSE,
  parameter int E_HOLD      = DEF_E_HOLD,
  parameter int NIBBLE_GAP  = DEF_NIBBLE_GAP,
  parameter int EXEC_SHORT  = DEF_EXEC_SHORT,
  parameter int EXEC_LONG   = DEF_EXEC_LONG,
  parameter int POWERUP_CYC = DEF_POWERUP,
  parameter int INIT_DLY_A  = DEF_INIT_DLY_A,
  parameter int INIT_DLY_B  = DEF_INIT_DLY_B,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_4,
  output logic       lcd_5,
  output logic       lcd_6,
  output logic       lcd_7
);

`ifdef LCD_INIT_SEQ_EN
  localparam state_t RESET_STATE = INIT_WAIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic             expired;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             low_q, low_d;
  logic             single_q, single_d;
  dly_sel_t         dsel_q, dsel_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       nib_q, nib_d;

`ifdef LCD_INIT_SEQ_EN
  logic [INIT_IDX_W-1:0] step_q, step_d, rom_idx;
  init_step_t            rom_step;
  logic                  load_init;

  assign rom_idx = step_q + 1'b1;

  lcd_init_rom u_init_rom (
    .idx  (rom_idx),
    .step (rom_step)
  );
`endif

  // A duration of N cycles is held while the counter runs 0..N-1.
  function automatic logic [CNT_W-1:0] cyc_lim(input int n);
    return CNT_W'(n - 1);
  endfunction

  function automatic logic [CNT_W-1:0] exec_lim(input dly_sel_t sel);
    case (sel)
      DLY_LONG:    return cyc_lim(EXEC_LONG);
      DLY_INIT_A:  return cyc_lim(INIT_DLY_A);
      DLY_INIT_B:  return cyc_lim(INIT_DLY_B);
      DLY_POWERUP: return cyc_lim(POWERUP_CYC);
      default:     return cyc_lim(EXEC_SHORT);
    endcase
  endfunction

  always_comb begin
    lim = '0;
    case (state_q)
      SETUP:     lim = cyc_lim(E_SETUP);
      PULSE:     lim = cyc_lim(E_PULSE);
      HOLD:      lim = cyc_lim(E_HOLD);
      GAP:       lim = cyc_lim(NIBBLE_GAP);
      EXEC:      lim = exec_lim(dsel_q);
`ifdef LCD_INIT_SEQ_EN
      INIT_WAIT: lim = exec_lim(DLY_POWERUP);
`endif
      default:   lim = '0;
    endcase
  end

  assign expired = (cnt_q == lim);

  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    data_d      = data_q;
    low_d       = low_q;
    single_d    = single_q;
    dsel_d      = dsel_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    nib_d       = nib_q;
`ifdef LCD_INIT_SEQ_EN
    step_d      = step_q;
    load_init   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          rs_d     = cmd_rs;
          data_d   = cmd_data;
          low_d    = 1'b0;
          single_d = 1'b0;
          dsel_d   = is_long_cmd(cmd_rs, cmd_data) ? DLY_LONG : DLY_SHORT;
          state_d  = SETUP;
        end
      end
      SETUP: if (expired) state_d = PULSE;
      PULSE: if (expired) state_d = HOLD;
      HOLD:  if (expired) state_d = (low_q || single_q) ? EXEC : GAP;
      GAP: begin
        if (expired) begin
          low_d   = 1'b1;
          state_d = SETUP;
        end
      end
      EXEC: begin
        if (expired) begin
`ifdef LCD_INIT_SEQ_EN
          if (init_done_q) begin
            state_d = IDLE;
          end else if (step_q == INIT_IDX_W'(INIT_STEPS - 1)) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            load_init = 1'b1;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT_WAIT: if (expired) load_init = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

`ifdef LCD_INIT_SEQ_EN
    if (load_init) begin
      step_d   = rom_idx;
      rs_d     = 1'b0;
      data_d   = rom_step.data;
      single_d = rom_step.single_nibble;
      dsel_d   = rom_step.delay_sel;
      low_d    = 1'b0;
      state_d  = SETUP;
    end
`else
    init_done_d = 1'b1;
`endif

    // Pins are updated only on SETUP entry and otherwise keep their last value.
    if ((state_d == SETUP) && (state_q != SETUP)) begin
      lcd_rs_d = rs_d;
      nib_d    = low_d ? data_d[3:0] : data_d[7:4];
    end

    cnt_d   = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + 1'b1;
    lcd_e_d = (state_d == PULSE);
    ready_d = (state_d == IDLE) && init_done_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      low_q       <= 1'b0;
      single_q    <= 1'b0;
      dsel_q      <= DLY_SHORT;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      nib_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      low_q       <= low_d;
      single_q    <= single_d;
      dsel_q      <= dsel_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      nib_q       <= nib_d;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= '0;
    else        step_q <= step_d;
  end
`endif

  // The latched byte is always written before it is used, so it needs no reset.
  always_ff @(posedge clk) begin
    rs_q   <= rs_d;
    data_q <= data_d;
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign {lcd_7, lcd_6, lcd_5, lcd_4} = nib_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Randomized bench for lcd_cmd_sequencer with a pulse-level scoreboard model.
// Builds with or without LCD_INIT_SEQ_EN; the model follows the same macro.
module tb_lcd_cmd_sequencer;

  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 1;
  localparam int G  = 3;
  localparam int ES = 10;
  localparam int EL = 40;
  localparam int PU = 20;
  localparam int IA = 30;
  localparam int IB = 15;

  logic       clk, reset;
  logic       cmd_valid, cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready, busy, init_done;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7;

  lcd_cmd_sequencer #(
    .E_SETUP(S), .E_PULSE(P), .E_HOLD(H), .NIBBLE_GAP(G),
    .EXEC_SHORT(ES), .EXEC_LONG(EL), .POWERUP_CYC(PU),
    .INIT_DLY_A(IA), .INIT_DLY_B(IB), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .busy(busy),
    .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every expected E pulse with its rs, nibble and rising cycle.
  typedef struct {
    int rs;
    int nib;
    int t;
  } pulse_t;

  pulse_t exp_q[$];
  int exp_rdy = -1;
  int exp_id  = -1;

  task automatic push(input int rs, input int nib, input int t);
    pulse_t p;
    p.rs = rs; p.nib = nib; p.t = t;
    exp_q.push_back(p);
  endtask

  function automatic int exec_of(input int rs, input int d);
    return (rs == 0 && d < 4) ? EL : ES;
  endfunction

  // Byte accepted at edge T: high nibble E rises after E_SETUP, low one after the gap.
  task automatic model_byte(input int rs, input int d, input int t);
    push(rs, d / 16, t + S);
    push(rs, d % 16, t + S + P + H + G + S);
    exp_rdy = t + 2 * (S + P + H) + G + exec_of(rs, d);
  endtask

`ifdef LCD_INIT_SEQ_EN
  int init_single[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int init_byte[8]   = '{'h30, 'h30, 'h30, 'h20, 'h28, 'h0C, 'h06, 'h01};
  int init_dly[8]    = '{IA, IB, ES, ES, ES, ES, ES, EL};
`endif

  // r is the first sampled cycle after reset release; the next edge is the first active one.
  task automatic model_reset(input int r);
`ifdef LCD_INIT_SEQ_EN
    int t;
    t = r + PU;
    for (int i = 0; i < 8; i++) begin
      push(0, init_byte[i] / 16, t + S);
      if (init_single[i] != 0) begin
        t += S + P + H + init_dly[i];
      end else begin
        push(0, init_byte[i] % 16, t + S + P + H + G + S);
        t += 2 * (S + P + H) + G + init_dly[i];
      end
    end
    exp_rdy = t;
`else
    exp_rdy = r + 1;
`endif
    exp_id = exp_rdy;
  endtask

  logic       e_prev, rdy_prev, id_prev, rst_seen, acc_pend;
  int         e_start;
  logic [4:0] e_word;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      e_prev   = 1'b0;
      rdy_prev = 1'b0;
      id_prev  = 1'b0;
      rst_seen = 1'b0;
      acc_pend = 1'b0;
      exp_rdy  = -1;
      exp_id   = -1;
    end else begin
      if (!rst_seen) begin
        rst_seen = 1'b1;
        model_reset(cyc);
      end
      if (acc_pend) begin
        chk("ready_drop", int'(cmd_ready), 0);
        acc_pend = 1'b0;
      end
      if (init_done && !id_prev) chk("init_done_time", cyc, exp_id);
      if (cmd_ready && !rdy_prev) begin
        chk("ready_time", cyc, exp_rdy);
        chk("init_with_ready", int'(init_done), 1);
        chk("busy_with_ready", int'(busy), 0);
        exp_rdy = -1;
      end
      if (cmd_valid && cmd_ready) begin
        model_byte(int'(cmd_rs), int'(cmd_data), cyc + 1);
        acc_pend = 1'b1;
      end
      if (lcd_e && !e_prev) begin
        if (exp_q.size() == 0) begin
          chk("e_unexpected", 1, 0);
        end else begin
          pulse_t p;
          p = exp_q.pop_front();
          chk("e_rise_cycle", cyc, p.t);
          chk("e_rs", int'(lcd_rs), p.rs);
          chk("e_nibble", int'({lcd_7, lcd_6, lcd_5, lcd_4}), p.nib);
          chk("e_rw", int'(lcd_rw), 0);
        end
        e_start = cyc;
        e_word  = {lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4};
      end
      if (!lcd_e && e_prev) begin
        chk("e_width", cyc - e_start, P);
        chk("e_hold", int'({lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4}), int'(e_word));
      end
      e_prev   = lcd_e;
      rdy_prev = cmd_ready;
      id_prev  = init_done;
    end
  end

  // While not ready, valid and data are randomized: none of it may be taken.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 4000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_rs    = 1'($urandom);
      cmd_data  = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_rs    = 1'($urandom);
    cmd_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int n, input logic [8:0] b0, input logic [8:0] b1,
                             input logic [8:0] b2);
    logic [8:0] b[3];
    int         i, k;
    logic       rdy;
    b[0] = b0; b[1] = b1; b[2] = b2;
    i = 0; k = 0;
    cmd_valid = 1'b1;
    {cmd_rs, cmd_data} = b[0];
    rdy = cmd_ready;
    while (i < n && k < 8000) begin
      @(posedge clk); #1;
      k++;
      if (rdy) begin
        i++;
        if (i < n) {cmd_rs, cmd_data} = b[i];
      end
      rdy = cmd_ready;
    end
    cmd_valid = 1'b0;
    chk("stream_done", i, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_nib", int'({lcd_7, lcd_6, lcd_5, lcd_4}), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_init_done", int'(init_done), 0);
    reset = 1'b1;

    wait_ready();
    send_byte(1'b1, 8'h41);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h03);
    send_byte(1'b1, 8'h02);
    send_stream(2, 9'h148, 9'h149, 9'h000);

    for (int i = 0; i < 25; i++) begin
      logic [7:0] d;
      logic       rs;
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      send_byte(rs, d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 3; i++) begin
      send_stream(3, 9'($urandom), 9'($urandom_range(0, 3)), 9'($urandom));
    end

    // Reset in the middle of the low-nibble E pulse.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h5A;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (S + P + H + G + S + 1) @(posedge clk);
    #1;
    chk("pre_reset_e_high", int'(lcd_e), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_e", int'(lcd_e), 0);
    chk("async_rst_ready", int'(cmd_ready), 0);
    chk("async_rst_busy", int'(busy), 1);
    chk("async_rst_rs", int'(lcd_rs), 0);
    chk("async_rst_nib", int'({lcd_7, lcd_6, lcd_5, lcd_4}), 0);
    chk("async_rst_init_done", int'(init_done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    send_byte(1'b1, 8'h7E);
    wait_ready();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Byte-level command/data sequencer for the 16x2 HD44780-style character LCD driven over its 4-bit bus (lcd_rs, lcd_rw, lcd_e, lcd_4..lcd_7). It accepts one byte at a time from an upstream text/frame engine over a valid/ready handshake. It optionally runs the power-up initialisation itself. Each byte is split into high and low nibbles, each framed with a timed E pulse, followed by the HD44780 execution delay. It is the only block that drives the LCD pins; display-content engines sit above it and never touch E timing.

## Interface
- E_SETUP, 2: cycles RS/data are stable before E rises (40 ns at 50 MHz).
- E_PULSE, 12: cycles E is high (240 ns).
- E_HOLD, 1: cycles data is held after E falls.
- NIBBLE_GAP, 50: idle cycles between high and low nibble.
- EXEC_SHORT, 2000: post-byte wait for normal commands/data (40 us).
- EXEC_LONG, 82000: post-byte wait for clear/home (1.64 ms).
- POWERUP_CYC, 750000: initial wait before the first init nibble (15 ms).
- CNT_W, 20: delay counter width; must hold the largest parameter.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  upstream has a byte.
- cmd_rs  in  1  0 = instruction, 1 = character data.
- cmd_data  in  8  byte to send.
- cmd_ready  out  1  sequencer can accept a byte this cycle.
- busy  out  1  transfer, delay or init in progress.
- init_done  out  1  LCD initialised; stays high until reset.
- lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control; lcd_rw is tied 0.
- lcd_4..lcd_7  out  1 each  LCD data nibble (lcd_7 = MSB).

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_4..7=0, cmd_ready=0, busy=1, init_done=0; counters 0; state INIT_WAIT (macro on) or IDLE (macro off).
- States: INIT_WAIT, IDLE, SETUP, PULSE, HOLD, GAP, EXEC.
- Handshake: a byte is accepted on a rising edge with cmd_valid & cmd_ready. cmd_rs and cmd_data are latched, and cmd_ready drops the next cycle. Upstream may change inputs freely after acceptance. cmd_valid while cmd_ready=0 is ignored and never queued.
- Byte flow: IDLE -> SETUP(high nibble, E_SETUP) -> PULSE(E_PULSE) -> HOLD(E_HOLD) -> GAP(NIBBLE_GAP) -> SETUP(low nibble) -> PULSE -> HOLD -> EXEC -> IDLE.
- Single-nibble steps (init only) skip GAP and the low nibble.
- Delay selection: EXEC uses EXEC_LONG when cmd_rs=0 and cmd_data[7:2]==0 (clear 0x01, home 0x02/0x03). Otherwise it uses EXEC_SHORT.
- lcd_rs and the nibble are driven from SETUP entry through HOLD exit. Outside those states they hold their last value, and lcd_e is 0.
- Counters load parameter−1 on state entry and leave the state when they reach 0, so a value of N gives exactly N cycles. A parameter value of 0 is illegal.
- cmd_ready = (state==IDLE) & init_done, registered.
- busy = ~cmd_ready.
- Asserting reset mid-transfer immediately forces lcd_e=0 and the reset values. The whole init sequence then reruns from the start.

## Timing
- Accept at edge T: the nibble appears at T+1; lcd_e is high for cycles T+1+E_SETUP through T+E_SETUP+E_PULSE.
- Accept-to-ready latency: 2·(E_SETUP+E_PULSE+E_HOLD) + NIBBLE_GAP + EXEC + 1 cycles. With defaults this is 30+50+2000+1 = 2081 cycles for a short byte.
- Back-to-back: if cmd_valid is held high, the next byte is accepted on the first cycle cmd_ready=1. There are no bubbles beyond that.

## Configuration
- LCD_INIT_SEQ_EN defined: after reset, the block runs the 4-bit init sequence before init_done rises:
  - wait POWERUP_CYC;
  - nibble 0x3, wait 205000; nibble 0x3, wait 5000; nibble 0x3, wait EXEC_SHORT; nibble 0x2, wait EXEC_SHORT;
  - bytes 0x28, 0x0C, 0x06, then 0x01 with EXEC_LONG.
  - All init steps use rs=0. init_done and cmd_ready rise together on the cycle after the final EXEC.
- Undefined: there is no init ROM and no INIT_WAIT state. The block starts in IDLE. init_done is driven 1 and cmd_ready rises on the first cycle after reset deasserts. Upstream is responsible for the init sequence.

## Structure
- Shared package lcd_pkg holds:
  - the state enum;
  - default timing constants (including 205000/5000 init waits);
  - the init step record {single_nibble, data[7:0], delay_sel};
  - the init step count (9).
- One sub-module, lcd_init_rom: a combinational step-index -> init step record lookup, instantiated only under LCD_INIT_SEQ_EN.

## Test plan
All scenarios use scaled parameters: E_SETUP=2, E_PULSE=4, E_HOLD=1, NIBBLE_GAP=3, EXEC_SHORT=10, EXEC_LONG=40, POWERUP_CYC=20.
- Macro off, release reset, send rs=1 data=0x41: first nibble 0x4 and second 0x1 with rs=1; lcd_e high exactly 4 cycles each, starting 2 cycles after nibble change; cmd_ready back after 2·7+3+10+1=28 cycles.
- Macro off, send rs=0 data=0x01: EXEC lasts 40 cycles and ready returns at cycle 58. Sending 0x04 instead uses 10 cycles.
- Macro on, release reset: E-pulse nibble sequence 3,3,3,2,2,8,0,C,0,6,0,1. init_done=0 and cmd_ready=0 throughout; both rise on the same cycle.
- cmd_valid held high with bytes 0x48,0x49: both transferred in order with no gap beyond one ready cycle. Toggling cmd_data during a transfer has no effect.
- Assert reset during PULSE of the low nibble: lcd_e=0 within the same cycle (asynchronous). All outputs take their reset values, and the init sequence restarts from INIT_WAIT.
